mbox_ebox_responder: RTL and testbench

- MBOX-side responder for the EBOX memory request interface. It is the far end of the request/response handshake that the EBOX memory-control logic drives.
- Accepts single-word read, write and read-pause-write (RPW) requests. It services them from a local word array after a programmable access latency, then returns a one-cycle response with read data or a nonexistent-memory (NXM) flag.
- Serves as the bench and bring-up MBOX stand-in until the cache/core-memory path exists.

---
 rtl/mbox_ebox_responder_if.sv | 45 ++++
 rtl/mbox_ebox_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mbox_ebox_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbox_ebox_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mbox_ebox_responder_if
// Description : EBOX <-> MBOX memory request/response bundle.
//               master = EBOX memory-control side (drives requests)
//               slave  = MBOX responder side (drives responses)
//   eboxReq     EBOX->MBOX  single-cycle request strobe
//   eboxRead    EBOX->MBOX  read qualifier
//   eboxWrite   EBOX->MBOX  write qualifier (read+write = RPW read phase)
//   eboxAddr    EBOX->MBOX  22-bit physical word address
//   eboxWrData  EBOX->MBOX  36-bit write data
//   eboxCancel  EBOX->MBOX  abort in-flight request / release RPW lock
//   mboxBusy    MBOX->EBOX  request in flight
//   mboxRespIn  MBOX->EBOX  one-cycle response strobe
//   mboxRdData  MBOX->EBOX  read data, zero outside the response cycle
//   mboxNXM     MBOX->EBOX  nonexistent-memory flag
//   mboxRPWLock MBOX->EBOX  RPW lock held
// Revision    : 1.0  initial release
// ============================================================================
interface mbox_ebox_responder_if;

  logic        eboxReq;
  logic        eboxRead;
  logic        eboxWrite;
  logic [21:0] eboxAddr;
  logic [35:0] eboxWrData;
  logic        eboxCancel;
  logic        mboxBusy;
  logic        mboxRespIn;
  logic [35:0] mboxRdData;
  logic        mboxNXM;
  logic        mboxRPWLock;

  modport master (
    output eboxReq, eboxRead, eboxWrite, eboxAddr, eboxWrData, eboxCancel,
    input  mboxBusy, mboxRespIn, mboxRdData, mboxNXM, mboxRPWLock
  );

  modport slave (
    input  eboxReq, eboxRead, eboxWrite, eboxAddr, eboxWrData, eboxCancel,
    output mboxBusy, mboxRespIn, mboxRdData, mboxNXM, mboxRPWLock
  );

endinterface
`default_nettype wire

// File: rtl/mbox_ebox_responder.sv
`default_nettype none
// ============================================================================
// Module      : mbox_ebox_responder
// Description : MBOX-side stand-in for the EBOX memory request interface.
//               Services single-word read, write and read-pause-write (RPW)
//               requests from a local 36-bit word array after LATENCY cycles
//               and returns a one-cycle response carrying read data or an
//               NXM flag.
// Ports       : mboxClk  - MBOX clock
//               reset    - synchronous active-high reset
//               bus      - mbox_ebox_responder_if.slave request/response bundle
// Parameters  : MEM_WORDS   - implemented words; addresses >= MEM_WORDS are NXM
//               LATENCY     - accept-to-response cycles, legal range 1..15
//               RPW_TIMEOUT - idle cycles before an RPW lock is abandoned
// Revision    : 1.0  initial release
// ============================================================================
module mbox_ebox_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 3,
  parameter int RPW_TIMEOUT = 64
) (
  input  logic                        mboxClk,
  input  logic                        reset,
  mbox_ebox_responder_if.slave        bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          TMR_W     = (RPW_TIMEOUT > 1) ? $clog2(RPW_TIMEOUT) : 1;
  localparam logic [22:0] MEM_LIMIT = 23'(MEM_WORDS);
  localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RPW_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCESS    = 3'd1,
    RESPOND   = 3'd2,
    RPW_HOLD  = 3'd3,
    RPW_WRITE = 3'd4
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [21:0]      addr_q;     // captured / held address
  logic [35:0]      wdata_q;    // captured write data
  logic             op_rd;      // captured read qualifier
  logic             op_wr;      // captured write qualifier
  logic [3:0]       cnt;        // access latency down-counter
  logic [TMR_W-1:0] hold_tmr;   // RPW lock age
  logic             rpw_next;   // current response is a good RPW read phase

  // Registered outputs
  logic             busy;
  logic             resp;
  logic [35:0]      rd_data;
  logic             nxm;
  logic             lock;

  // Word array; deliberately not reset
  logic [35:0]      mem [MEM_WORDS];

  // --------------------------------------------------------------------------
  // Response-entry decode
  //
  // Every path into RESPOND is funnelled through go_resp so that the array
  // read, the array write and the NXM decision are made in exactly one place,
  // on the clock edge that enters RESPOND. The resp_* signals describe the
  // transaction being completed on that edge.
  // --------------------------------------------------------------------------
  logic             req_valid;
  logic             hold_match;
  logic             go_resp;
  logic [21:0]      resp_addr;
  logic [35:0]      resp_wdata;
  logic             resp_rd;
  logic             resp_wr;
  logic             resp_rpw;
  logic             force_nxm;
  logic             resp_nxm;
  logic [IDX_W-1:0] resp_idx;
  logic             mem_we;

  assign req_valid  = bus.eboxReq && (bus.eboxRead || bus.eboxWrite);

  // The only request that continues a held RPW: write-only to the held word.
  assign hold_match = bus.eboxWrite && !bus.eboxRead && (bus.eboxAddr == addr_q);

  always_comb begin
    go_resp    = 1'b0;
    resp_addr  = addr_q;
    resp_wdata = wdata_q;
    resp_rd    = 1'b0;
    resp_wr    = 1'b0;
    resp_rpw   = 1'b0;
    force_nxm  = 1'b0;
    case (state)
      IDLE: begin
        // With a single-cycle latency the accept edge is also the
        // response-entry edge, so the live request fields are used.
        if (req_valid && (LATENCY == 1)) begin
          go_resp    = 1'b1;
          resp_addr  = bus.eboxAddr;
          resp_wdata = bus.eboxWrData;
          resp_rd    = bus.eboxRead;
          resp_wr    = bus.eboxWrite && !bus.eboxRead;
          resp_rpw   = bus.eboxRead && bus.eboxWrite;
        end
      end
      ACCESS: begin
        // Counter value 1 on this edge means RESPOND lands exactly LATENCY
        // cycles after the accept cycle. Cancel wins over completion.
        if (!bus.eboxCancel && (cnt <= 4'd1)) begin
          go_resp  = 1'b1;
          resp_rd  = op_rd;
          resp_wr  = op_wr && !op_rd;  // RPW read phase never writes
          resp_rpw = op_rd && op_wr;
        end
      end
      RPW_HOLD: begin
        // Any request other than the matching write breaks the RPW and is
        // answered with an error and no array update.
        if (bus.eboxReq && !hold_match) begin
          go_resp   = 1'b1;
          force_nxm = 1'b1;
        end
      end
      RPW_WRITE: begin
        go_resp = 1'b1;
        resp_wr = 1'b1;
      end
      default: begin
        go_resp = 1'b0;
      end
    endcase
  end

  assign resp_idx = resp_addr[IDX_W-1:0];
  assign resp_nxm = force_nxm || ({1'b0, resp_addr} >= MEM_LIMIT);
  assign mem_we   = go_resp && resp_wr && !resp_nxm && !reset;

  // --------------------------------------------------------------------------
  // Word array write port
  // --------------------------------------------------------------------------
  always_ff @(posedge mboxClk) begin
    if (mem_we) begin
      mem[resp_idx] <= resp_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge mboxClk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      resp     <= 1'b0;
      rd_data  <= '0;
      nxm      <= 1'b0;
      lock     <= 1'b0;
      cnt      <= '0;
      hold_tmr <= '0;
      rpw_next <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_rd    <= 1'b0;
      op_wr    <= 1'b0;
    end else begin
      // Response fields are only non-zero during the RESPOND cycle.
      resp    <= 1'b0;
      nxm     <= 1'b0;
      rd_data <= '0;

      if (go_resp) begin
        state    <= RESPOND;
        busy     <= 1'b1;
        resp     <= 1'b1;
        lock     <= 1'b0;
        nxm      <= resp_nxm;
        rd_data  <= (resp_rd && !resp_nxm) ? mem[resp_idx] : '0;
        rpw_next <= resp_rpw && !resp_nxm;
        addr_q   <= resp_addr;
      end else begin
        case (state)
          IDLE: begin
            // Cancel has no meaning here and is ignored, even alongside a
            // request.
            if (req_valid) begin
              state   <= ACCESS;
              busy    <= 1'b1;
              addr_q  <= bus.eboxAddr;
              wdata_q <= bus.eboxWrData;
              op_rd   <= bus.eboxRead;
              op_wr   <= bus.eboxWrite;
              cnt     <= LAT_LOAD;
            end
          end
          ACCESS: begin
            if (bus.eboxCancel) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          RESPOND: begin
            busy     <= 1'b0;
            rpw_next <= 1'b0;
            if (rpw_next) begin
              state    <= RPW_HOLD;
              lock     <= 1'b1;
              hold_tmr <= '0;
            end else begin
              state <= IDLE;
            end
          end
          RPW_HOLD: begin
            // Only a matching write reaches here with eboxReq set; request
            // beats cancel, cancel beats timeout.
            if (bus.eboxReq) begin
              state   <= RPW_WRITE;
              busy    <= 1'b1;
              wdata_q <= bus.eboxWrData;
            end else if (bus.eboxCancel || (hold_tmr == TMR_LAST)) begin
              state <= IDLE;
              lock  <= 1'b0;
            end else begin
              hold_tmr <= hold_tmr + TMR_W'(1);
            end
          end
          default: begin
            // RPW_WRITE always leaves through go_resp; anything else is
            // unreachable and recovers to IDLE.
            state <= IDLE;
            busy  <= 1'b0;
            lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.mboxBusy    = busy;
  assign bus.mboxRespIn  = resp;
  assign bus.mboxRdData  = rd_data;
  assign bus.mboxNXM     = nxm;
  assign bus.mboxRPWLock = lock;

endmodule
`default_nettype wire

// File: tb/tb_mbox_ebox_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbox_ebox_responder
// Description : Directed self-checking bench for mbox_ebox_responder.
//               dut  : MEM_WORDS=1024, LATENCY=3, RPW_TIMEOUT=64
//               dut1 : LATENCY=1, fed the same request stream
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mbox_ebox_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mbox_ebox_responder_if bus ();
  mbox_ebox_responder_if bus1 ();

  assign bus1.eboxReq    = bus.eboxReq;
  assign bus1.eboxRead   = bus.eboxRead;
  assign bus1.eboxWrite  = bus.eboxWrite;
  assign bus1.eboxAddr   = bus.eboxAddr;
  assign bus1.eboxWrData = bus.eboxWrData;
  assign bus1.eboxCancel = bus.eboxCancel;

  mbox_ebox_responder #(.MEM_WORDS(1024), .LATENCY(3), .RPW_TIMEOUT(64)) dut (
    .mboxClk (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  mbox_ebox_responder #(.MEM_WORDS(1024), .LATENCY(1), .RPW_TIMEOUT(64)) dut1 (
    .mboxClk (clk),
    .reset   (reset),
    .bus     (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic drive_idle();
    bus.eboxReq    = 1'b0;
    bus.eboxRead   = 1'b0;
    bus.eboxWrite  = 1'b0;
    bus.eboxAddr   = '0;
    bus.eboxWrData = '0;
    bus.eboxCancel = 1'b0;
  endtask

  // One-cycle request; returns at the sample point of cycle t0+1.
  task automatic issue(input logic rd, input logic wr, input logic [21:0] a,
                       input logic [35:0] d);
    @(negedge clk);
    bus.eboxReq    = 1'b1;
    bus.eboxRead   = rd;
    bus.eboxWrite  = wr;
    bus.eboxAddr   = a;
    bus.eboxWrData = d;
    @(negedge clk);
    bus.eboxReq    = 1'b0;
    bus.eboxRead   = 1'b0;
    bus.eboxWrite  = 1'b0;
  endtask

  // Full transaction on dut with a bounded wait for the response.
  task automatic xact(input logic rd, input logic wr, input logic [21:0] a,
                      input logic [35:0] d, output logic [35:0] rdata,
                      output logic nx, output int lat);
    int n = 0;
    issue(rd, wr, a, d);
    while (bus.mboxRespIn !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rdata = bus.mboxRdData;
    nx    = bus.mboxNXM;
    lat   = n + 1;
    checks++;
    if (bus.mboxRespIn !== 1'b1) begin
      errors++;
      $display("FAIL xact_timeout addr=%o: respIn=%b, required 1 within 20 cycles", a, bus.mboxRespIn);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mboxBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.mboxBusy); end
    checks++;
    if (bus.mboxRespIn !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b, required 0", bus.mboxRespIn); end
    checks++;
    if (bus.mboxRdData !== 36'd0) begin errors++; $display("FAIL reset_data: got %o, required 0", bus.mboxRdData); end
    checks++;
    if (bus.mboxNXM !== 1'b0) begin errors++; $display("FAIL reset_nxm: got %b, required 0", bus.mboxNXM); end
    checks++;
    if (bus.mboxRPWLock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b, required 0", bus.mboxRPWLock); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic exp_busy, exp_resp;
    // Write: busy t0+1..t0+3, response exactly at t0+3
    issue(1'b0, 1'b1, 22'o17, 36'o123456701234);
    for (int c = 1; c <= 4; c++) begin
      exp_busy = (c <= 3);
      exp_resp = (c == 3);
      checks++;
      if (bus.mboxBusy !== exp_busy) begin errors++; $display("FAIL wr_busy t0+%0d: got %b, required %b", c, bus.mboxBusy, exp_busy); end
      checks++;
      if (bus.mboxRespIn !== exp_resp) begin errors++; $display("FAIL wr_resp t0+%0d: got %b, required %b", c, bus.mboxRespIn, exp_resp); end
      if (c == 3) begin
        checks++;
        if (bus.mboxNXM !== 1'b0) begin errors++; $display("FAIL wr_nxm: got %b, required 0", bus.mboxNXM); end
      end
      if (c < 4) @(negedge clk);
    end
    // Read back with the same timing
    issue(1'b1, 1'b0, 22'o17, 36'd0);
    for (int c = 1; c <= 4; c++) begin
      exp_busy = (c <= 3);
      exp_resp = (c == 3);
      checks++;
      if (bus.mboxRespIn !== exp_resp) begin errors++; $display("FAIL rd_resp t0+%0d: got %b, required %b", c, bus.mboxRespIn, exp_resp); end
      checks++;
      if (bus.mboxBusy !== exp_busy) begin errors++; $display("FAIL rd_busy t0+%0d: got %b, required %b", c, bus.mboxBusy, exp_busy); end
      if (c == 2) begin
        checks++;
        if (bus.mboxRdData !== 36'd0) begin errors++; $display("FAIL rd_data_early: got %o, required 0", bus.mboxRdData); end
      end
      if (c == 3) begin
        checks++;
        if (bus.mboxRdData !== 36'o123456701234) begin errors++; $display("FAIL rd_data: got %o, required 123456701234", bus.mboxRdData); end
        checks++;
        if (bus.mboxNXM !== 1'b0) begin errors++; $display("FAIL rd_nxm: got %b, required 0", bus.mboxNXM); end
      end
      if (c < 4) @(negedge clk);
    end
  endtask

  task automatic test_nxm();
    logic [35:0] d;
    logic        nx;
    int          lat;
    xact(1'b0, 1'b1, 22'd0, 36'o765432107654, d, nx, lat);
    xact(1'b0, 1'b1, 22'd1023, 36'o246024602460, d, nx, lat);
    xact(1'b1, 1'b0, 22'o2000, 36'd0, d, nx, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL nxm_rd_latency: got %0d, required 3", lat); end
    checks++;
    if (nx !== 1'b1) begin errors++; $display("FAIL nxm_rd_flag: got %b, required 1", nx); end
    checks++;
    if (d !== 36'd0) begin errors++; $display("FAIL nxm_rd_data: got %o, required 0", d); end
    // NXM writes whose low bits alias words 0 and 1023 must not land
    xact(1'b0, 1'b1, 22'o2000, 36'o111111111111, d, nx, lat);
    checks++;
    if (nx !== 1'b1) begin errors++; $display("FAIL nxm_wr_flag: got %b, required 1", nx); end
    xact(1'b0, 1'b1, 22'h3FFFFF, 36'o222222222222, d, nx, lat);
    checks++;
    if (nx !== 1'b1) begin errors++; $display("FAIL nxm_wr_top_flag: got %b, required 1", nx); end
    xact(1'b1, 1'b0, 22'd0, 36'd0, d, nx, lat);
    checks++;
    if (d !== 36'o765432107654) begin errors++; $display("FAIL nxm_alias0: got %o, required 765432107654", d); end
    xact(1'b1, 1'b0, 22'd1023, 36'd0, d, nx, lat);
    checks++;
    if (d !== 36'o246024602460 || nx !== 1'b0) begin errors++; $display("FAIL last_word: got %o nxm=%b, required 246024602460 nxm=0", d, nx); end
  endtask

  task automatic test_rpw();
    logic [35:0] d;
    logic        nx;
    int          lat;
    xact(1'b0, 1'b1, 22'd5, 36'd7, d, nx, lat);
    issue(1'b1, 1'b1, 22'd5, 36'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mboxRespIn !== 1'b1 || bus.mboxRdData !== 36'd7 || bus.mboxNXM !== 1'b0) begin
      errors++; $display("FAIL rpw_read: got resp=%b data=%o nxm=%b, required resp=1 data=7 nxm=0", bus.mboxRespIn, bus.mboxRdData, bus.mboxNXM);
    end
    @(negedge clk);
    checks++;
    if (bus.mboxRPWLock !== 1'b1 || bus.mboxBusy !== 1'b0) begin
      errors++; $display("FAIL rpw_hold: got lock=%b busy=%b, required lock=1 busy=0", bus.mboxRPWLock, bus.mboxBusy);
    end
    issue(1'b0, 1'b1, 22'd5, 36'd10);
    checks++;
    if (bus.mboxBusy !== 1'b1 || bus.mboxRPWLock !== 1'b1 || bus.mboxRespIn !== 1'b0) begin
      errors++; $display("FAIL rpw_write_phase: got busy=%b lock=%b resp=%b, required 1 1 0", bus.mboxBusy, bus.mboxRPWLock, bus.mboxRespIn);
    end
    @(negedge clk);
    checks++;
    if (bus.mboxRespIn !== 1'b1 || bus.mboxNXM !== 1'b0 || bus.mboxRPWLock !== 1'b0) begin
      errors++; $display("FAIL rpw_write_resp: got resp=%b nxm=%b lock=%b, required 1 0 0", bus.mboxRespIn, bus.mboxNXM, bus.mboxRPWLock);
    end
    @(negedge clk);
    checks++;
    if (bus.mboxBusy !== 1'b0 || bus.mboxRespIn !== 1'b0) begin
      errors++; $display("FAIL rpw_done: got busy=%b resp=%b, required 0 0", bus.mboxBusy, bus.mboxRespIn);
    end
    xact(1'b1, 1'b0, 22'd5, 36'd0, d, nx, lat);
    checks++;
    if (d !== 36'd10) begin errors++; $display("FAIL rpw_readback: got %o, required 12", d); end
  endtask

  task automatic test_rpw_abort();
    logic [35:0] d;
    logic        nx;
    int          lat;
    int          held;
    int          seen;
    xact(1'b0, 1'b1, 22'd6, 36'o666, d, nx, lat);
    issue(1'b1, 1'b1, 22'd5, 36'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mboxRespIn !== 1'b1 || bus.mboxRdData !== 36'd10) begin
      errors++; $display("FAIL rpw2_read: got resp=%b data=%o, required resp=1 data=12", bus.mboxRespIn, bus.mboxRdData);
    end
    @(negedge clk);
    issue(1'b0, 1'b1, 22'd6, 36'o777);
    checks++;
    if (bus.mboxRespIn !== 1'b1 || bus.mboxNXM !== 1'b1 || bus.mboxRPWLock !== 1'b0 || bus.mboxRdData !== 36'd0) begin
      errors++; $display("FAIL rpw_mismatch: got resp=%b nxm=%b lock=%b data=%o, required 1 1 0 0", bus.mboxRespIn, bus.mboxNXM, bus.mboxRPWLock, bus.mboxRdData);
    end
    @(negedge clk);
    checks++;
    if (bus.mboxBusy !== 1'b0 || bus.mboxRPWLock !== 1'b0) begin
      errors++; $display("FAIL rpw_mismatch_idle: got busy=%b lock=%b, required 0 0", bus.mboxBusy, bus.mboxRPWLock);
    end
    xact(1'b1, 1'b0, 22'd6, 36'd0, d, nx, lat);
    checks++;
    if (d !== 36'o666) begin errors++; $display("FAIL rpw_mismatch_nowrite: got %o, required 666", d); end
    // Abandoned RPW: lock held for exactly RPW_TIMEOUT cycles, no response
    issue(1'b1, 1'b1, 22'd5, 36'd0);
    repeat (2) @(negedge clk);
    held = 0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mboxRPWLock === 1'b1) held++;
      if (bus.mboxRespIn === 1'b1) seen++;
    end
    checks++;
    if (held !== 64) begin errors++; $display("FAIL rpw_timeout_len: got %0d lock cycles, required 64", held); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rpw_timeout_resp: got %0d responses, required 0", seen); end
  endtask

  task automatic test_cancel();
    logic [35:0] d;
    logic        nx;
    int          lat;
    int          seen;
    xact(1'b0, 1'b1, 22'o20, 36'o111, d, nx, lat);
    issue(1'b0, 1'b1, 22'o20, 36'o222);
    bus.eboxCancel = 1'b1;
    @(negedge clk);
    bus.eboxCancel = 1'b0;
    checks++;
    if (bus.mboxBusy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b, required 0", bus.mboxBusy); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mboxRespIn === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL cancel_resp: got %0d responses, required 0", seen); end
    xact(1'b1, 1'b0, 22'o20, 36'd0, d, nx, lat);
    checks++;
    if (d !== 36'o111) begin errors++; $display("FAIL cancel_nowrite: got %o, required 111", d); end
    // A write strobe during ACCESS is dropped
    issue(1'b1, 1'b0, 22'o20, 36'd0);
    bus.eboxReq    = 1'b1;
    bus.eboxWrite  = 1'b1;
    bus.eboxAddr   = 22'o20;
    bus.eboxWrData = 36'o333;
    @(negedge clk);
    bus.eboxReq    = 1'b0;
    bus.eboxWrite  = 1'b0;
    checks++;
    if (bus.mboxRespIn !== 1'b0) begin errors++; $display("FAIL ignored_early: got resp=%b, required 0", bus.mboxRespIn); end
    @(negedge clk);
    checks++;
    if (bus.mboxRespIn !== 1'b1 || bus.mboxRdData !== 36'o111) begin
      errors++; $display("FAIL ignored_first_resp: got resp=%b data=%o, required 1 111", bus.mboxRespIn, bus.mboxRdData);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mboxRespIn === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL ignored_extra_resp: got %0d, required 0", seen); end
    // Cancel arriving with a request in IDLE does not block acceptance
    @(negedge clk);
    bus.eboxReq    = 1'b1;
    bus.eboxRead   = 1'b1;
    bus.eboxAddr   = 22'o20;
    bus.eboxCancel = 1'b1;
    @(negedge clk);
    bus.eboxReq    = 1'b0;
    bus.eboxRead   = 1'b0;
    bus.eboxCancel = 1'b0;
    checks++;
    if (bus.mboxBusy !== 1'b1) begin errors++; $display("FAIL idle_cancel_accept: got busy=%b, required 1", bus.mboxBusy); end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mboxRespIn !== 1'b1 || bus.mboxRdData !== 36'o111) begin
      errors++; $display("FAIL idle_cancel_resp: got resp=%b data=%o, required 1 111", bus.mboxRespIn, bus.mboxRdData);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [35:0] d;
    logic        nx;
    int          lat;
    int          seen;
    xact(1'b0, 1'b1, 22'o21, 36'o555, d, nx, lat);
    issue(1'b0, 1'b1, 22'o21, 36'o444);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mboxBusy !== 1'b0 || bus.mboxRespIn !== 1'b0 || bus.mboxRPWLock !== 1'b0 || bus.mboxNXM !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got busy=%b resp=%b lock=%b nxm=%b, required all 0", bus.mboxBusy, bus.mboxRespIn, bus.mboxRPWLock, bus.mboxNXM);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mboxRespIn === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_resp: got %0d responses, required 0", seen); end
    xact(1'b1, 1'b0, 22'o21, 36'd0, d, nx, lat);
    checks++;
    if (d !== 36'o555) begin errors++; $display("FAIL reset_mid_nowrite: got %o, required 555", d); end
  endtask

  task automatic test_latency1();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(1'b0, 1'b1, 22'd3, 36'o135713571357);
    checks++;
    if (bus1.mboxRespIn !== 1'b1 || bus1.mboxBusy !== 1'b1 || bus1.mboxNXM !== 1'b0) begin
      errors++; $display("FAIL lat1_wr_resp: got resp=%b busy=%b nxm=%b, required 1 1 0", bus1.mboxRespIn, bus1.mboxBusy, bus1.mboxNXM);
    end
    @(negedge clk);
    checks++;
    if (bus1.mboxRespIn !== 1'b0 || bus1.mboxBusy !== 1'b0) begin
      errors++; $display("FAIL lat1_wr_after: got resp=%b busy=%b, required 0 0", bus1.mboxRespIn, bus1.mboxBusy);
    end
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b0, 22'd3, 36'd0);
    checks++;
    if (bus1.mboxRespIn !== 1'b1 || bus1.mboxRdData !== 36'o135713571357) begin
      errors++; $display("FAIL lat1_rd: got resp=%b data=%o, required 1 135713571357", bus1.mboxRespIn, bus1.mboxRdData);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_write_read();
    test_nxm();
    test_rpw();
    test_rpw_abort();
    test_cancel();
    test_reset_mid();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
